gpr_mt: RTL and testbench

//  Multi-thread general purpose register file for the pipeline: one bank of 2**ADDR_W

---
 rtl/gpr_mt_if.sv | 33 +++
 rtl/gpr_mt.sv | 117 +++++++++++
 tb/tb_gpr_mt.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/gpr_mt_if.sv
// Register-file port bundle: two combinational read ports, one write port, clear control.
interface gpr_mt_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TID_W  = 2
);
    logic [TID_W-1:0]  rd_tid_0;
    logic [ADDR_W-1:0] rd_addr_0;
    logic [DATA_W-1:0] rd_data_0;
    logic [TID_W-1:0]  rd_tid_1;
    logic [ADDR_W-1:0] rd_addr_1;
    logic [DATA_W-1:0] rd_data_1;
    logic              we;
    logic [TID_W-1:0]  wr_tid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_req;
    logic [TID_W-1:0]  clr_tid;
    logic              clr_busy;
    logic              ready;

    modport master (
        output rd_tid_0, rd_addr_0, rd_tid_1, rd_addr_1,
        output we, wr_tid, wr_addr, wr_data, clr_req, clr_tid,
        input  rd_data_0, rd_data_1, clr_busy, ready
    );

    modport slave (
        input  rd_tid_0, rd_addr_0, rd_tid_1, rd_addr_1,
        input  we, wr_tid, wr_addr, wr_data, clr_req, clr_tid,
        output rd_data_0, rd_data_1, clr_busy, ready
    );
endinterface

// File: rtl/gpr_mt.sv
// Multi-thread GPR file: one bank per thread, 2R/1W, write-first bypass,
// sequential zeroing of all banks after reset (INIT) and of one bank on request (TCLR).
// Optional feature macro GPR_MT_R0_ZERO_EN: index 0 of every bank is hardwired to zero.
module gpr_mt #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TID_W  = 2
) (
    input  logic     clk,
    input  logic     reset,
    gpr_mt_if.slave  bus
);
    localparam int NTHR  = 1 << TID_W;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {INIT, IDLE, TCLR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W:0]   clr_ptr, ptr_nxt;
    logic [TID_W-1:0]  cur_tid, tid_nxt;
    logic              ready_q, busy_q;
    logic              wr_ok;
    logic [ADDR_W-1:0] ptr_idx;

    logic [DATA_W-1:0] mem [NTHR][DEPTH];

    assign ptr_idx = clr_ptr[ADDR_W-1:0];

    // FSM and clear-pointer registers; ready/busy are registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= INIT;
            clr_ptr <= '0;
            cur_tid <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state   <= state_nxt;
            clr_ptr <= ptr_nxt;
            cur_tid <= tid_nxt;
            ready_q <= (state_nxt != INIT);
            busy_q  <= (state_nxt != IDLE);
        end
    end

    // Next-state logic: walk clr_ptr across the bank(s) being cleared
    always_comb begin
        state_nxt = state;
        ptr_nxt   = clr_ptr;
        tid_nxt   = cur_tid;
        case (state)
            INIT, TCLR: begin
                ptr_nxt = clr_ptr + 1'b1;
                if (clr_ptr == (ADDR_W+1)'(DEPTH-1))
                    state_nxt = IDLE;
            end
            IDLE: begin
                if (bus.clr_req) begin
                    tid_nxt   = bus.clr_tid;
                    ptr_nxt   = '0;
                    state_nxt = TCLR;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    // A user write survives unless INIT is running or it targets the bank being cleared
    always_comb begin
        wr_ok = bus.we && (state != INIT) && !(state == TCLR && bus.wr_tid == cur_tid);
`ifdef GPR_MT_R0_ZERO_EN
        if (bus.wr_addr == '0)
            wr_ok = 1'b0;
`endif
    end

    // Storage: user write plus the clear stream (never the same bank during TCLR)
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[bus.wr_tid][bus.wr_addr] <= bus.wr_data;
        if (state == INIT) begin
            for (int t = 0; t < NTHR; t++)
                mem[t][ptr_idx] <= '0;
        end else if (state == TCLR) begin
            mem[cur_tid][ptr_idx] <= '0;
        end
    end

    logic [1:0][TID_W-1:0]  rtid;
    logic [1:0][ADDR_W-1:0] radr;

    assign rtid = {bus.rd_tid_1, bus.rd_tid_0};
    assign radr = {bus.rd_addr_1, bus.rd_addr_0};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [DATA_W-1:0] rd_q;
        // Read resolution: not-ready / bank-under-clear force zero, then bypass, then storage
        always_comb begin
            rd_q = mem[rtid[p]][radr[p]];
            if (!ready_q)
                rd_q = '0;
            else if (state == TCLR && rtid[p] == cur_tid)
                rd_q = '0;
`ifdef GPR_MT_R0_ZERO_EN
            else if (radr[p] == '0)
                rd_q = '0;
`endif
            else if (wr_ok && bus.wr_tid == rtid[p] && bus.wr_addr == radr[p])
                rd_q = bus.wr_data;
        end
    end

    assign bus.rd_data_0 = g_rd[0].rd_q;
    assign bus.rd_data_1 = g_rd[1].rd_q;
    assign bus.ready     = ready_q;
    assign bus.clr_busy  = busy_q;
endmodule

// File: tb/tb_gpr_mt.sv
// Bench for gpr_mt: bank-level reference model, per-cycle compare, directed and random stimulus.
module tb_gpr_mt;
`ifdef GPR_MT_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif
    localparam int CLR_CYC = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gpr_mt_if #(.DATA_W(32), .ADDR_W(5), .TID_W(2)) bus ();
    gpr_mt #(.DATA_W(32), .ADDR_W(5), .TID_W(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: whole-bank view; a clear zeroes its bank at once and
    // blocks that bank (reads 0, writes dropped) until the clear time has run out.
    logic [31:0] mm [4][32];
    bit m_init = 1'b1;
    int m_rem  = CLR_CYC;
    int m_tid  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit w_ok();
        if (!bus.we || m_init) return 1'b0;
        if (m_rem > 0 && int'(bus.wr_tid) == m_tid) return 1'b0;
        if (R0Z && bus.wr_addr == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rd(input int t, input int a);
        if (m_init) return 32'h0;
        if (m_rem > 0 && t == m_tid) return 32'h0;
        if (R0Z && a == 0) return 32'h0;
        if (w_ok() && int'(bus.wr_tid) == t && int'(bus.wr_addr) == a) return bus.wr_data;
        return mm[t][a];
    endfunction

    // Model update on each active edge
    always @(posedge clk) begin
        if (reset) begin
            m_init = 1'b1;
            m_rem  = CLR_CYC;
            for (int t = 0; t < 4; t++)
                for (int a = 0; a < 32; a++) mm[t][a] = 32'h0;
        end else begin
            if (w_ok()) mm[bus.wr_tid][bus.wr_addr] = bus.wr_data;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) m_init = 1'b0;
            end else if (bus.clr_req) begin
                m_tid = int'(bus.clr_tid);
                m_rem = CLR_CYC;
                for (int a = 0; a < 32; a++) mm[m_tid][a] = 32'h0;
            end
        end
    end

    // Per-cycle compare, mid low phase after inputs have settled
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("rd_data_0", bus.rd_data_0, exp_rd(int'(bus.rd_tid_0), int'(bus.rd_addr_0)));
            chk("rd_data_1", bus.rd_data_1, exp_rd(int'(bus.rd_tid_1), int'(bus.rd_addr_1)));
            chk("ready", {31'h0, bus.ready}, {31'h0, !m_init});
            chk("clr_busy", {31'h0, bus.clr_busy}, {31'h0, m_rem > 0});
        end
    end

    task automatic idle_in();
        bus.we = 1'b0; bus.clr_req = 1'b0;
    endtask

    task automatic wr(input int t, input int a, input logic [31:0] d);
        bus.we = 1'b1; bus.wr_tid = 2'(t); bus.wr_addr = 5'(a); bus.wr_data = d;
    endtask

    task automatic rd(input int t0, input int a0, input int t1, input int a1);
        bus.rd_tid_0 = 2'(t0); bus.rd_addr_0 = 5'(a0);
        bus.rd_tid_1 = 2'(t1); bus.rd_addr_1 = 5'(a1);
    endtask

    // Count cycles with ready low after reset release (bounded)
    task automatic count_init(input string nm);
        int cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            reset = 1'b0; idle_in();
            rd($urandom_range(3), $urandom_range(31), $urandom_range(3), $urandom_range(31));
            #3;
            if (bus.ready) break;
            cnt++;
        end
        chk(nm, cnt, CLR_CYC);
        chk({nm, "_busy_low"}, {31'h0, bus.clr_busy}, 32'h0);
    endtask

    initial begin
        int cnt;
        rd(0, 0, 0, 0); idle_in();
        bus.wr_tid = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.clr_tid = '0;

        // 1: reset one cycle, INIT lasts 32 cycles, every bank reads 0
        @(posedge clk); #1 chk_en = 1'b1;
        count_init("init_len");
        for (int t = 0; t < 4; t++)
            for (int a = 0; a < 32; a += 2) begin
                @(negedge clk); rd(t, a, t, a + 1); #3;
                chk("init_zero0", bus.rd_data_0, 32'h0);
                chk("init_zero1", bus.rd_data_1, 32'h0);
            end

        // 2: same-cycle bypass only for matching thread
        @(negedge clk); wr(1, 5, 32'hDEADBEEF); rd(1, 5, 2, 5); #3;
        chk("bypass_t1r5", bus.rd_data_0, 32'hDEADBEEF);
        chk("nobypass_t2r5", bus.rd_data_1, 32'h0);
        @(negedge clk); idle_in(); #3;
        chk("stored_t1r5", bus.rd_data_0, 32'hDEADBEEF);

        // 3/4: fill t2, clear it; mid-clear writes; second request ignored
        for (int i = 1; i < 32; i++) begin
            @(negedge clk); wr(2, i, 32'h100 + i); rd(2, i, 3, 9);
        end
        @(negedge clk); wr(3, 9, 32'h333);
        @(negedge clk); idle_in(); rd(2, 4, 2, 31); #3;
        chk("t2r4_filled", bus.rd_data_0, 32'h104);
        @(negedge clk); bus.clr_req = 1'b1; bus.clr_tid = 2'd2;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); idle_in(); rd(2, $urandom_range(31), 0, 7);
            if (i == 2) wr(0, 7, 32'h55);
            if (i == 3) wr(2, 7, 32'h66);
            if (i == 4) begin bus.clr_req = 1'b1; bus.clr_tid = 2'd3; end
            #3;
            if (!bus.clr_busy) break;
            chk("tclr_t2_zero", bus.rd_data_0, 32'h0);
            cnt++;
        end
        chk("tclr_len", cnt, CLR_CYC);
        @(negedge clk); idle_in(); rd(2, 7, 0, 7); #3;
        chk("t2r7_dropped", bus.rd_data_0, 32'h0);
        chk("t0r7_kept", bus.rd_data_1, 32'h55);
        @(negedge clk); rd(3, 9, 2, 31); #3;
        chk("t3r9_untouched", bus.rd_data_0, 32'h333);
        chk("t2r31_cleared", bus.rd_data_1, 32'h0);

        // 5: reset 10 cycles into a clear restarts INIT
        @(negedge clk); bus.clr_req = 1'b1; bus.clr_tid = 2'd1;
        repeat (10) begin @(negedge clk); idle_in(); end
        reset = 1'b1;
        count_init("reinit_len");
        @(negedge clk); rd(1, 5, 0, 7); #3;
        chk("reinit_t1r5", bus.rd_data_0, 32'h0);
        chk("reinit_t0r7", bus.rd_data_1, 32'h0);

        // 6: index 0 behaviour
        @(negedge clk); wr(0, 0, 32'hFFFFFFFF); rd(0, 0, 0, 0); #3;
        chk("r0_bypass", bus.rd_data_0, R0Z ? 32'h0 : 32'hFFFFFFFF);
        @(negedge clk); idle_in(); #3;
        chk("r0_stored", bus.rd_data_0, R0Z ? 32'h0 : 32'hFFFFFFFF);

        // Random traffic with collisions, clears and occasional resets
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(599) == 0);
            bus.we = ($urandom_range(2) != 0);
            bus.wr_tid = 2'($urandom_range(3));
            bus.wr_addr = 5'($urandom_range(i[0] ? 3 : 31));
            bus.wr_data = $urandom;
            bus.clr_req = ($urandom_range(39) == 0);
            bus.clr_tid = 2'($urandom_range(3));
            if ($urandom_range(1) == 0) rd(int'(bus.wr_tid), int'(bus.wr_addr), $urandom_range(3), int'(bus.wr_addr));
            else rd($urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(31));
        end
        @(negedge clk); reset = 1'b0; idle_in();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
